// File: rtl/audio_stream_scheduler.sv
// Frame-paced stereo stream scheduler: 16-deep host FIFO mixed with synth audio once per frame.
// Define AUDIO_STREAM_SAT_EN to saturate the mix; otherwise the 17-bit sum wraps to 16 bits.
module audio_stream_scheduler (
    input  logic               vga_clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [3:0]         rate_div,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic signed [15:0] s_left,
    input  logic signed [15:0] s_right,
    input  logic signed [15:0] synth_l,
    input  logic signed [15:0] synth_r,
    output logic signed [15:0] sample_l,
    output logic signed [15:0] sample_r,
    output logic               frame_tick,
    output logic [4:0]         level,
    output logic               underrun,
    input  logic               underrun_clr
);

`ifdef AUDIO_STREAM_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

    state_e             state_q;
    logic [5:0]         phase_q;
    logic [3:0]         divide_q;
    logic [3:0]         wr_ptr_q;
    logic [3:0]         rd_ptr_q;
    logic [4:0]         level_q;
    logic               underrun_q;
    logic signed [15:0] sample_l_q;
    logic signed [15:0] sample_r_q;
    logic [31:0]        mem [16];

    logic               push;
    logic               pop;
    logic               starve;
    logic signed [15:0] stream_l;
    logic signed [15:0] stream_r;
    logic signed [16:0] sum_l;
    logic signed [16:0] sum_r;

    function automatic logic [15:0] reduce_sum(input logic [16:0] s);
        if (SatEn && (s[16] != s[15])) begin
            return s[16] ? 16'h8000 : 16'h7FFF;
        end
        return s[15:0];
    endfunction

    assign frame_tick = (phase_q == 6'd63) && (divide_q == rate_div);
    assign s_ready    = (state_q != StIdle) && (level_q != 5'd16);
    assign push       = s_valid && s_ready;
    assign pop        = frame_tick && (state_q == StRun) && (level_q != 5'd0);
    assign starve     = frame_tick && (state_q == StRun) && (level_q == 5'd0);

    always_comb begin
        stream_l = 16'sd0;
        stream_r = 16'sd0;
        if (pop) begin
            stream_l = mem[rd_ptr_q][31:16];
            stream_r = mem[rd_ptr_q][15:0];
        end
        sum_l = {synth_l[15], synth_l} + {stream_l[15], stream_l};
        sum_r = {synth_r[15], synth_r} + {stream_r[15], stream_r};
    end

    always_ff @(posedge vga_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {s_left, s_right};
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            state_q    <= StIdle;
            phase_q    <= 6'd0;
            divide_q   <= 4'd0;
            wr_ptr_q   <= 4'd0;
            rd_ptr_q   <= 4'd0;
            level_q    <= 5'd0;
            underrun_q <= 1'b0;
            sample_l_q <= 16'sd0;
            sample_r_q <= 16'sd0;
        end else begin
            phase_q <= phase_q + 6'd1;
            // Live compare: if rate_div drops below divide, the counter runs on and wraps at 15.
            if (phase_q == 6'd63) begin
                divide_q <= (divide_q == rate_div) ? 4'd0 : divide_q + 4'd1;
            end

            if (frame_tick) begin
                sample_l_q <= reduce_sum(sum_l);
                sample_r_q <= reduce_sum(sum_r);
            end

            if (starve) begin
                underrun_q <= 1'b1;
            end else if (underrun_clr) begin
                underrun_q <= 1'b0;
            end

            if (!enable) begin
                state_q  <= StIdle;
                wr_ptr_q <= 4'd0;
                rd_ptr_q <= 4'd0;
                level_q  <= 5'd0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        wr_ptr_q <= 4'd0;
                        rd_ptr_q <= 4'd0;
                        level_q  <= 5'd0;
                        state_q  <= StPrime;
                    end
                    StPrime, StRun: begin
                        if (push) begin
                            wr_ptr_q <= wr_ptr_q + 4'd1;
                        end
                        if (pop) begin
                            rd_ptr_q <= rd_ptr_q + 4'd1;
                        end
                        level_q <= level_q + {4'd0, push} - {4'd0, pop};
                        if (state_q == StPrime && frame_tick && level_q >= 5'd8) begin
                            state_q <= StRun;
                        end
                        // A push landing on a starved tick stays queued for the next frame.
                        if (starve) begin
                            state_q <= StPrime;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign level    = level_q;
    assign underrun = underrun_q;
    assign sample_l = sample_l_q;
    assign sample_r = sample_r_q;

endmodule

// File: doc/audio_stream_scheduler.md
AUDIO_STREAM_SCHEDULER -- requirements
Module: audio_stream_scheduler

Interface
REQ-001 SHALL have port vga_clk, input, 1: sole clock; all logic updates on its rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have port enable, input, 1: streaming enable.
REQ-004 SHALL have port rate_div, input, 4: frame period = 64*(rate_div+1) vga_clk cycles.
REQ-005 SHALL have port s_valid, input, 1: host stereo sample valid.
REQ-006 SHALL have port s_ready, output, 1: FIFO can accept.
REQ-007 SHALL have ports s_left and s_right, input, 16 signed each: host stream sample.
REQ-008 SHALL have ports synth_l and synth_r, input, 16 signed each: synthesizer voice mix.
REQ-009 SHALL have ports sample_l and sample_r, output, 16 signed each: mixed sample to the DAC path.
REQ-010 SHALL have port frame_tick, output, 1: one-cycle pulse on the last cycle of each frame.
REQ-011 SHALL have port level, output, 5: FIFO occupancy, 0..16.
REQ-012 SHALL have port underrun, output, 1: sticky underrun flag.
REQ-013 SHALL have port underrun_clr, input, 1: clears underrun.

Function
REQ-014 SHALL hold a 16-entry x 32-bit FIFO ({left,right}) with 4-bit read/write pointers that wrap 15->0.
REQ-015 SHALL drive s_ready = (level != 16) combinationally; push occurs iff s_valid && s_ready.
REQ-016 SHALL count frames with a 6-bit phase counter plus a 4-bit divide counter; frame_tick is high when phase==63 && divide==rate_div.
REQ-017 SHALL compare against rate_div live; if rate_div changes below the current divide count, the divide counter wraps at 15 before ticking.
REQ-018 SHALL implement states IDLE, PRIME and RUN.
REQ-019 IDLE: FIFO flushed (level forced 0, pushes ignored, s_ready=0); transition to PRIME when enable=1.
REQ-020 PRIME: pushes accepted, no pops; transition to RUN on frame_tick when level>=8.
REQ-021 RUN: on frame_tick pop one entry if level>0; if level==0, set underrun, use stream value 0 for that frame, and go to PRIME.
REQ-022 Any state SHALL go to IDLE on the cycle after enable=0, which takes priority over all other transitions.
REQ-023 Push and pop in the same cycle SHALL leave level unchanged.
REQ-024 A push into an empty FIFO coinciding with a tick SHALL NOT bypass: it counts as an underrun, and the pushed entry remains in the FIFO.
REQ-025 Stream contribution SHALL be the popped entry in RUN and 0 in IDLE/PRIME.
REQ-026 On frame_tick, sample_l/sample_r SHALL register synth + stream, computed in 17 bits and reduced per REQ-031; valid on the cycle after frame_tick and held until the next tick.
REQ-027 underrun_clr SHALL clear underrun; a simultaneous set wins.

Reset
REQ-028 On rst, the block SHALL enter IDLE with pointers=0, level=0, phase=0, divide=0.
REQ-029 On rst, sample_l=0, sample_r=0, frame_tick=0, underrun=0, s_ready=0.
REQ-030 rst mid-frame or mid-push SHALL discard all FIFO contents; the first tick after reset occurs 64*(rate_div+1) cycles later.

Configuration
REQ-031 With AUDIO_STREAM_SAT_EN defined, the 17-bit sum SHALL saturate to [-32768, 32767]; without it, the sum SHALL wrap (low 16 bits).

Verification
REQ-032 rate_div=0, enable=1, push 8 samples L=0x0100, R=-0x0100, synth=0 -> RUN at 1st tick; sample_l=0x0100, sample_r=0xFF00 one cycle after the 2nd tick; ticks 64 cycles apart.
REQ-033 Push 16 samples with s_valid held -> s_ready=0 at level=16; a 17th push is not accepted; level stays 16 until the next pop.
REQ-034 RUN with 1 entry, no further pushes -> 2nd tick sets underrun, stream=0, state=PRIME; underrun_clr in a later cycle clears it.
REQ-035 synth_l=0x7000, stream L=0x2000 -> sample_l=0x7FFF with AUDIO_STREAM_SAT_EN, 0x9000 without; synth_l=0x8000 + 0x8000 -> 0x8000 sat, 0x0000 wrap.
REQ-036 rate_div=3 -> frame_tick every 256 cycles; enable=0 mid-frame -> IDLE next cycle, level=0, sample outputs = synth only from the next tick.
REQ-037 rst asserted at level=5 mid-frame -> all outputs 0 the next cycle; first tick 64*(rate_div+1) cycles after rst deasserts.
